asyncio_writer: RTL and testbench

- Downstream stage of the asyncio reader path: the stream-to-memory sink.
- Takes a write request (length in words, start address, input select).
- Consumes that many 32-bit words from one selected valid/ready stream input and issues one memory write per word at consecutive word addresses (+4).
- Decouples stream and memory with a 2-entry buffer, then signals completion with a one-cycle `done` pulse.

---
 rtl/asyncio_writer.sv | 157 +++++++++++++++
 tb/tb_asyncio_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asyncio_writer.sv
// Stream-to-memory sink: drains one selected 32-bit valid/ready input into consecutive word writes.
// Optional build macro ASYNCIO_WRITER_BYTE_SWAP_EN stores each accepted word byte-reversed.
module asyncio_writer #(
  parameter int INPUT_ID_WIDTH   = 1,
  parameter int NO_OF_AXI_INPUTS = 1,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int LENGTH_WIDTH     = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LENGTH_WIDTH-1:0]        length,
  input  logic [ADDRESS_WIDTH-1:0]       address,
  input  logic [INPUT_ID_WIDTH-1:0]      input_id,
  input  logic [NO_OF_AXI_INPUTS-1:0]    axi_in_valid,
  input  logic [NO_OF_AXI_INPUTS*32-1:0] axi_in_data,
  output logic [NO_OF_AXI_INPUTS-1:0]    axi_in_ready,
  output logic [ADDRESS_WIDTH-1:0]       mem_address,
  output logic [31:0]                    mem_data,
  output logic                           mem_write,
  input  logic                           mem_ready,
  output logic                           busy,
  output logic                           done,
  output logic [LENGTH_WIDTH-1:0]        remaining
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [LENGTH_WIDTH-1:0]     remaining_q, remaining_d;
  logic [LENGTH_WIDTH-1:0]     to_accept_q, to_accept_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [INPUT_ID_WIDTH-1:0]   id_q, id_d;
  logic [31:0]                 buf0_q, buf0_d;
  logic [31:0]                 buf1_q, buf1_d;
  logic [1:0]                  count_q, count_d;

  logic        start;
  logic        s_ready;
  logic        sel_valid;
  logic [31:0] sel_data;
  logic [31:0] in_word;
  logic        accept;
  logic        wr;

  function automatic logic [31:0] store_fmt(input logic [31:0] d);
`ifdef ASYNCIO_WRITER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NO_OF_AXI_INPUTS; i++) begin
      if (int'(id_q) == i) begin
        sel_valid = axi_in_valid[i];
        sel_data  = axi_in_data[i*32 +: 32];
      end
    end
  end

  assign start     = (length != '0);
  assign s_ready   = (state_q == S_RUN) && (count_q < 2'd2) && (to_accept_q != '0);
  assign accept    = s_ready && sel_valid;
  assign mem_write = (state_q == S_RUN) && (count_q != 2'd0);
  assign wr        = mem_write && mem_ready;
  assign in_word   = store_fmt(sel_data);

  always_comb begin
    axi_in_ready = '0;
    for (int i = 0; i < NO_OF_AXI_INPUTS; i++) begin
      axi_in_ready[i] = s_ready && (int'(id_q) == i);
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = buf0_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign remaining   = remaining_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    to_accept_d = to_accept_q;
    addr_d      = addr_q;
    id_d        = id_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    count_d     = count_q;

    // A new request aborts whatever is in flight, including buffered words.
    if (start) begin
      state_d     = S_RUN;
      remaining_d = length;
      to_accept_d = length;
      addr_d      = address;
      id_d        = input_id;
      count_d     = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          if (wr && (remaining_q == LENGTH_WIDTH'(1))) state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (accept) to_accept_d = to_accept_q - LENGTH_WIDTH'(1);
      if (wr) begin
        addr_d      = addr_q + ADDRESS_WIDTH'(4);
        remaining_d = remaining_q - LENGTH_WIDTH'(1);
      end

      case ({accept, wr})
        2'b10: begin
          if (count_q == 2'd0) buf0_d = in_word;
          else                 buf1_d = in_word;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) buf0_d = buf1_q;
          count_d = count_q - 2'd1;
        end
        // Ready is low at count 2, so a simultaneous pair only happens at count 1.
        2'b11: buf0_d = in_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      to_accept_q <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      to_accept_q <= to_accept_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_asyncio_writer.sv
// Directed bench for asyncio_writer with two stream inputs; non-selected input always carries noise.
module tb_asyncio_writer;
  localparam int N  = 2;
  localparam int IW = 1;
  localparam int AW = 32;
  localparam int LW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] length;
  logic [AW-1:0] address;
  logic [IW-1:0] input_id;
  logic [N-1:0]  axi_in_valid;
  logic [N*32-1:0] axi_in_data;
  logic [N-1:0]  axi_in_ready;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data;
  logic          mem_write;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic [LW-1:0] remaining;

  always #5 clk = ~clk;

  asyncio_writer #(
    .INPUT_ID_WIDTH(IW), .NO_OF_AXI_INPUTS(N), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .length(length), .address(address), .input_id(input_id),
    .axi_in_valid(axi_in_valid), .axi_in_data(axi_in_data), .axi_in_ready(axi_in_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write),
    .mem_ready(mem_ready), .busy(busy), .done(done), .remaining(remaining)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 0;

  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          wr_cyc  [16];
  int          acc_cyc [16];
  logic [31:0] src     [8];
  int n_wr, n_acc, n_done, done_cyc, ready_bad, src_n, src_i;

  task automatic clear_logs();
    for (int k = 0; k < 16; k++) begin
      wr_addr[k] = '0; wr_data[k] = '0; wr_cyc[k] = -1; acc_cyc[k] = -1;
    end
    n_wr = 0; n_acc = 0; n_done = 0; done_cyc = -1; ready_bad = 0; src_n = 0; src_i = 0;
  endtask

  task automatic drive_noise();
    axi_in_valid = '0;
    axi_in_data  = {N{32'hBAD0BAD0}};
    axi_in_valid[1-sel] = 1'b1;
  endtask

  // One clock: present source word, log what the DUT does this cycle, advance.
  task automatic step(input logic mr);
    logic acc;
    mem_ready = mr;
    drive_noise();
    if (src_i < src_n) begin
      axi_in_valid[sel] = 1'b1;
      axi_in_data[sel*32 +: 32] = src[src_i];
    end
    #1;
    if (mem_write && mem_ready) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = mem_address; wr_data[n_wr] = mem_data; wr_cyc[n_wr] = cyc;
      end
      n_wr++;
    end
    acc = axi_in_ready[sel] && axi_in_valid[sel];
    if (acc) begin
      if (n_acc < 16) acc_cyc[n_acc] = cyc;
      n_acc++;
    end
    if (axi_in_ready[1-sel]) ready_bad++;
    if (done) begin n_done++; done_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
    if (acc) src_i++;
  endtask

  task automatic start_req(input logic [LW-1:0] len, input logic [AW-1:0] a, input int id);
    sel = id;
    length = len; address = a; input_id = IW'(id);
    mem_ready = 1'b0;
    drive_noise();
    @(posedge clk); #1;
    cyc++;
    length = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; length = '0; address = '0; input_id = '0; mem_ready = 1'b1; sel = 0;
    drive_noise();
    axi_in_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (remaining !== '0) begin bad++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    total++; if (axi_in_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=00", axi_in_ready); end
    total++; if (mem_address !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", mem_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_basic();
    int s;
    clear_logs();
    src[0] = 32'hA0A0_0001; src[1] = 32'hB0B0_0002; src[2] = 32'hC0C0_0003; src_n = 3;
    start_req(24'd3, 32'h0000_0100, 0);
    s = cyc;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    repeat (8) step(1'b1);
    total++; if (acc_cyc[0] !== s) begin bad++; $display("FAIL basic_first_accept got=%0d exp=%0d", acc_cyc[0], s); end
    total++; if (n_wr !== 3) begin bad++; $display("FAIL basic_nwr got=%0d exp=3", n_wr); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (wr_addr[k] !== 32'h100 + 32'(4*k)) begin
        bad++; $display("FAIL basic_addr%0d got=%h exp=%h", k, wr_addr[k], 32'h100 + 32'(4*k));
      end
      total++;
      if (wr_data[k] !== src[k]) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", k, wr_data[k], src[k]); end
      total++;
      if (wr_cyc[k] !== s + 1 + k) begin bad++; $display("FAIL basic_wcyc%0d got=%0d exp=%0d", k, wr_cyc[k], s + 1 + k); end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL basic_ndone got=%0d exp=1", n_done); end
    total++; if (done_cyc !== s + 4) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, s + 4); end
    total++; if (remaining !== '0) begin bad++; $display("FAIL basic_remaining got=%0d exp=0", remaining); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stall();
    clear_logs();
    src[0] = 32'h1111_0000; src[1] = 32'h2222_0000; src[2] = 32'h3333_0000; src[3] = 32'h4444_0000; src_n = 4;
    start_req(24'd4, 32'h0000_0300, 0);
    repeat (5) step(1'b0);
    total++; if (n_acc !== 2) begin bad++; $display("FAIL stall_nacc got=%0d exp=2", n_acc); end
    total++; if (axi_in_ready[0] !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", axi_in_ready[0]); end
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL stall_mem_write got=%b exp=1", mem_write); end
    total++; if (mem_address !== 32'h300) begin bad++; $display("FAIL stall_addr_hold got=%h exp=300", mem_address); end
    total++; if (mem_data !== 32'h1111_0000) begin bad++; $display("FAIL stall_data_hold got=%h exp=11110000", mem_data); end
    total++; if (remaining !== 24'd4) begin bad++; $display("FAIL stall_remaining got=%0d exp=4", remaining); end
    repeat (12) step(1'b1);
    total++; if (n_wr !== 4) begin bad++; $display("FAIL stall_nwr got=%0d exp=4", n_wr); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wr_addr[k] !== 32'h300 + 32'(4*k)) begin
        bad++; $display("FAIL stall_addr%0d got=%h exp=%h", k, wr_addr[k], 32'h300 + 32'(4*k));
      end
      total++;
      if (wr_data[k] !== src[k]) begin bad++; $display("FAIL stall_data%0d got=%h exp=%h", k, wr_data[k], src[k]); end
    end
    total++;
    if (!(acc_cyc[2] > wr_cyc[0])) begin
      bad++; $display("FAIL stall_third_accept got=%0d exp_after=%0d", acc_cyc[2], wr_cyc[0]);
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL stall_ndone got=%0d exp=1", n_done); end
  endtask

  task automatic test_select();
    clear_logs();
    src[0] = 32'h5151_5151; src[1] = 32'h6262_6262; src_n = 2;
    start_req(24'd2, 32'h0000_0500, 1);
    repeat (8) step(1'b1);
    total++; if (ready_bad !== 0) begin bad++; $display("FAIL select_ready0 got=%0d exp=0", ready_bad); end
    total++; if (n_wr !== 2) begin bad++; $display("FAIL select_nwr got=%0d exp=2", n_wr); end
    total++; if (wr_data[0] !== 32'h5151_5151) begin bad++; $display("FAIL select_data0 got=%h exp=51515151", wr_data[0]); end
    total++; if (wr_data[1] !== 32'h6262_6262) begin bad++; $display("FAIL select_data1 got=%h exp=62626262", wr_data[1]); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL select_ndone got=%0d exp=1", n_done); end
    sel = 0;
  endtask

  task automatic test_restart();
    clear_logs();
    src[0] = 32'h7777_0001; src[1] = 32'h7777_0002; src_n = 2;
    start_req(24'd2, 32'h0000_0400, 0);
    step(1'b1);
    step(1'b1);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL restart_pre_nwr got=%0d exp=1", n_wr); end
    start_req(24'd1, 32'h0000_0200, 0);
    total++; if (remaining !== 24'd1) begin bad++; $display("FAIL restart_remaining got=%0d exp=1", remaining); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL restart_flush got=%b exp=0", mem_write); end
    src[0] = 32'h8888_0003; src_n = 1; src_i = 0;
    repeat (8) step(1'b1);
    total++; if (n_wr !== 2) begin bad++; $display("FAIL restart_nwr got=%0d exp=2", n_wr); end
    total++; if (wr_addr[1] !== 32'h200) begin bad++; $display("FAIL restart_addr got=%h exp=200", wr_addr[1]); end
    total++; if (wr_data[1] !== 32'h8888_0003) begin bad++; $display("FAIL restart_data got=%h exp=88880003", wr_data[1]); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL restart_ndone got=%0d exp=1", n_done); end
  endtask

  task automatic test_wrap();
    clear_logs();
    src[0] = 32'h9999_0001; src[1] = 32'h9999_0002; src_n = 2;
    start_req(24'd2, 32'hFFFF_FFFC, 0);
    repeat (8) step(1'b1);
    total++; if (n_wr !== 2) begin bad++; $display("FAIL wrap_nwr got=%0d exp=2", n_wr); end
    total++; if (wr_addr[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", wr_addr[0]); end
    total++; if (wr_addr[1] !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=00000000", wr_addr[1]); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL wrap_ndone got=%0d exp=1", n_done); end
  endtask

  task automatic test_swap_idle();
    logic [31:0] exp_word;
`ifdef ASYNCIO_WRITER_BYTE_SWAP_EN
    exp_word = 32'h4433_2211;
`else
    exp_word = 32'h1122_3344;
`endif
    clear_logs();
    src[0] = 32'h1122_3344; src_n = 1;
    start_req(24'd1, 32'h0000_0600, 0);
    repeat (6) step(1'b1);
    total++; if (wr_data[0] !== exp_word) begin bad++; $display("FAIL swap_data got=%h exp=%h", wr_data[0], exp_word); end
    axi_in_valid = '1;
    mem_ready = 1'b1;
    #1;
    total++; if (axi_in_ready !== '0) begin bad++; $display("FAIL idle_ready got=%b exp=00", axi_in_ready); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL idle_mem_write got=%b exp=0", mem_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_select();
    test_restart();
    test_wrap();
    test_swap_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
